// File: rtl/enigma_pkg.sv
// Shared plugboard definitions: letter widths, error codes, pair-entry states
// and small one-hot helpers used by the plugboard writer and its lookups.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int LETTER_W    = 5;

  typedef logic [NUM_LETTERS-1:0] letter_vec_t;
  typedef logic [LETTER_W-1:0]    letter_idx_t;

  // Error codes reported to the operator after a rejected key press
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_IN_USE = 2'd2,
    ERR_FULL   = 2'd3
  } err_code_e;

  // Pair-entry state machine
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HAVE_FIRST = 2'd1,
    ST_COMMIT     = 2'd2
  } pair_state_e;

  // True when exactly one letter is selected
  function automatic logic onehot_valid(input letter_vec_t v);
    return $onehot(v);
  endfunction

  // Letter index back to a one-hot letter; out-of-range indices give no letter
  function automatic letter_vec_t idx_to_onehot(input letter_idx_t idx);
    letter_vec_t v;
    v = '0;
    if (int'(idx) < NUM_LETTERS) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/plugboard_pair_loader_if.sv
// Signal bundle between the switches/keys/lookup paths and the plugboard writer.
// master = whoever drives switches, key, clear and lookup letters; slave = plugboard.
interface plugboard_pair_loader_if;
  import enigma_pkg::*;

  letter_vec_t letter_in;
  logic        enter_n;
  logic        clear;
  letter_vec_t fwd_in;
  letter_vec_t fwd_out;
  letter_vec_t ret_in;
  letter_vec_t ret_out;
  logic [3:0]  pair_count;
  logic        pending;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output letter_in, enter_n, clear, fwd_in, ret_in,
    input  fwd_out, ret_out, pair_count, pending, err, err_code
  );

  modport slave (
    input  letter_in, enter_n, clear, fwd_in, ret_in,
    output fwd_out, ret_out, pair_count, pending, err, err_code
  );

endinterface

// File: rtl/onehot_to_index.sv
// Converts a 26-bit one-hot letter into its 5-bit index plus a flag saying
// whether the input really was a single letter.
module onehot_to_index
  import enigma_pkg::*;
(
  input  letter_vec_t onehot,
  output letter_idx_t idx,
  output logic        valid
);

  // Encode the set bit; the index is only meaningful when valid is high
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (onehot[i]) idx = letter_idx_t'(i);
    end
    valid = onehot_valid(onehot);
  end

endmodule

// File: rtl/plugboard_pair_loader.sv
// Plugboard writer: takes letters one key press at a time, validates them,
// builds the reciprocal swap table and serves registered forward/return lookups.
module plugboard_pair_loader
  import enigma_pkg::*;
#(
  parameter int MAX_PAIRS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic                    CLOCK_50,
  input logic                    reset,
  plugboard_pair_loader_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_prev_q;
  logic                   press;

  letter_idx_t letter_idx;
  logic        letter_valid;
  letter_idx_t fwd_idx;
  logic        fwd_valid;
  letter_idx_t ret_idx;
  logic        ret_valid;

  letter_idx_t map_q [NUM_LETTERS];
  letter_vec_t plugged_q;
  pair_state_e state_q;
  letter_idx_t first_q;
  letter_idx_t second_q;
  logic [3:0]  pair_count_q;
  logic        pending_q;
  logic        err_q;
  err_code_e   err_code_q;
  letter_vec_t fwd_out_q;
  letter_vec_t ret_out_q;

  logic letter_plugged;
  logic pairs_full;

  onehot_to_index u_letter_idx (
    .onehot (bus.letter_in),
    .idx    (letter_idx),
    .valid  (letter_valid)
  );

  onehot_to_index u_fwd_idx (
    .onehot (bus.fwd_in),
    .idx    (fwd_idx),
    .valid  (fwd_valid)
  );

  onehot_to_index u_ret_idx (
    .onehot (bus.ret_in),
    .idx    (ret_idx),
    .valid  (ret_valid)
  );

  // Synchronise the raw key and remember the previous synced level for edge detection
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync_q     <= '1;
      key_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.enter_n};
      key_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press          = key_prev_q & ~sync_q[SYNC_STAGES-1];
  assign letter_plugged = plugged_q[letter_idx];
  assign pairs_full     = (pair_count_q == 4'(MAX_PAIRS));

  // Pair-entry FSM owning the swap table, plugged mask, counters and error reporting
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_idx_t'(i);
      plugged_q    <= '0;
      state_q      <= ST_IDLE;
      first_q      <= '0;
      second_q     <= '0;
      pair_count_q <= '0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      if (bus.clear) begin
        for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_idx_t'(i);
        plugged_q    <= '0;
        state_q      <= ST_IDLE;
        pair_count_q <= '0;
        pending_q    <= 1'b0;
        err_code_q   <= ERR_NONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press) begin
              if (!letter_valid) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_ONEHOT;
              end else if (letter_plugged) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_IN_USE;
              end else if (pairs_full) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_FULL;
              end else begin
                first_q    <= letter_idx;
                pending_q  <= 1'b1;
                err_code_q <= ERR_NONE;
                state_q    <= ST_HAVE_FIRST;
              end
            end
          end
          ST_HAVE_FIRST: begin
            if (press) begin
              if (bus.letter_in == '0) begin
                pending_q  <= 1'b0;
                err_code_q <= ERR_NONE;
                state_q    <= ST_IDLE;
              end else if (!letter_valid) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_ONEHOT;
              end else if (letter_plugged || (letter_idx == first_q)) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_IN_USE;
              end else begin
                second_q   <= letter_idx;
                err_code_q <= ERR_NONE;
                state_q    <= ST_COMMIT;
              end
            end
          end
          ST_COMMIT: begin
            map_q[first_q]      <= second_q;
            map_q[second_q]     <= first_q;
            plugged_q[first_q]  <= 1'b1;
            plugged_q[second_q] <= 1'b1;
            pair_count_q        <= pair_count_q + 4'd1;
            pending_q           <= 1'b0;
            state_q             <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered swap lookups; anything other than a single letter yields no letter
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fwd_out_q <= '0;
      ret_out_q <= '0;
    end else begin
      fwd_out_q <= fwd_valid ? idx_to_onehot(map_q[fwd_idx]) : '0;
      ret_out_q <= ret_valid ? idx_to_onehot(map_q[ret_idx]) : '0;
    end
  end

  assign bus.fwd_out    = fwd_out_q;
  assign bus.ret_out    = ret_out_q;
  assign bus.pair_count = pair_count_q;
  assign bus.pending    = pending_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule
